pe_array_ctrl: RTL and testbench

- Sequencer for an N x N systolic array of multiply-accumulate PEs; each PE passes its input right, its weight down and its output right.
- Runs one matrix-product job per `start`:
  - clears PE accumulators;
  - issues skewed per-row and per-column feed enables for k_len accumulation steps;
  - drives the PE `ctl` line to capture the accumulators;
  - shifts results out of the output chain, one column per cycle.
- Sits between the operand/result buffers and the PE array. Data values never pass through this block.

---
 rtl/pe_array_ctrl.sv | 153 +++++++++++++++
 tb/tb_pe_array_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_ctrl.sv
// Job sequencer for an N x N systolic MAC array: clear, skewed feed, capture, shift-out.
// Optional abort input/aborted pulse enabled by defining PE_ARRAY_CTRL_ABORT_EN.
module pe_array_ctrl #(
    parameter int N  = 4,
    parameter int KW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
`ifdef PE_ARRAY_CTRL_ABORT_EN
    input  logic                  abort,
    output logic                  aborted,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  pe_rst_n,
    output logic                  pe_ctl,
    output logic [KW:0]           feed_cnt,
    output logic [N-1:0]          row_en,
    output logic [N-1:0]          col_en,
    output logic                  out_valid,
    output logic [$clog2(N)-1:0]  out_col
);

    localparam int CW = KW + 1;
    localparam int OW = $clog2(N);
    localparam logic [CW-1:0] SKEW_LAST = CW'(2 * N - 3);
    localparam logic [OW-1:0] COL_LAST  = OW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_CAPTURE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   t_q, t_d;
    logic [OW-1:0]   col_q, col_d;
    logic [N-1:0]    en_q, en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pe_rst_n_q, pe_rst_n_d;
    logic            pe_ctl_q, pe_ctl_d;
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   feed_last;
`ifdef PE_ARRAY_CTRL_ABORT_EN
    logic            aborted_q, aborted_d;
`endif

    // Last FEED cycle: the final product needs 2N-2 extra hops to reach PE(N-1,N-1).
    assign feed_last = {1'b0, k_q} + SKEW_LAST;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d     = k_len;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR:   state_d = S_FEED;
            S_FEED:    if (t_q == feed_last) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_SHIFT;
            S_SHIFT:   if (col_q == '0) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
`ifdef PE_ARRAY_CTRL_ABORT_EN
        aborted_d = 1'b0;
        if (abort && (state_q == S_CLEAR || state_q == S_FEED ||
                      state_q == S_CAPTURE || state_q == S_SHIFT)) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end
`endif
    end

    // Outputs are registered from the next state so nothing reaches them combinationally.
    always_comb begin
        t_d         = '0;
        col_d       = '0;
        en_d        = '0;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        pe_rst_n_d  = (state_d != S_CLEAR);
        pe_ctl_d    = (state_d == S_CAPTURE);
        out_valid_d = (state_d == S_SHIFT);
        if (state_d == S_FEED && state_q == S_FEED) begin
            t_d = t_q + CW'(1);
        end
        if (state_d == S_SHIFT) begin
            col_d = (state_q == S_SHIFT) ? col_q - OW'(1) : COL_LAST;
        end
        if (state_d == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                en_d[i] = (t_d >= CW'(i)) && ((t_d - CW'(i)) < {1'b0, k_q});
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            t_q         <= '0;
            col_q       <= '0;
            en_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pe_rst_n_q  <= 1'b0;
            pe_ctl_q    <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef PE_ARRAY_CTRL_ABORT_EN
            aborted_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            t_q         <= t_d;
            col_q       <= col_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pe_rst_n_q  <= pe_rst_n_d;
            pe_ctl_q    <= pe_ctl_d;
            out_valid_q <= out_valid_d;
`ifdef PE_ARRAY_CTRL_ABORT_EN
            aborted_q   <= aborted_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pe_rst_n  = pe_rst_n_q;
    assign pe_ctl    = pe_ctl_q;
    assign feed_cnt  = t_q;
    assign row_en    = en_q;
    assign col_en    = en_q;
    assign out_valid = out_valid_q;
    assign out_col   = col_q;
`ifdef PE_ARRAY_CTRL_ABORT_EN
    assign aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed self-checking bench for pe_array_ctrl (N=4, KW=8): job timing, enable skew,
// k_len=0, ignored starts, mid-job reset and, when PE_ARRAY_CTRL_ABORT_EN is defined, abort.
module tb_pe_array_ctrl;

    localparam int N  = 4;
    localparam int KW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [KW-1:0] k_len;
    logic          busy;
    logic          done;
    logic          pe_rst_n;
    logic          pe_ctl;
    logic [KW:0]   feed_cnt;
    logic [N-1:0]  row_en;
    logic [N-1:0]  col_en;
    logic          out_valid;
    logic [1:0]    out_col;
`ifdef PE_ARRAY_CTRL_ABORT_EN
    logic          abort;
    logic          aborted;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;

    // Hand-derived enable patterns indexed by FEED cycle t.
    logic [3:0] tbl4 [10] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                              4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] tbl2 [8]  = '{4'b0001, 4'b0011, 4'b0110, 4'b1100,
                              4'b1000, 4'b0000, 4'b0000, 4'b0000};

    pe_array_ctrl #(.N(N), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
`ifdef PE_ARRAY_CTRL_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .busy      (busy),
        .done      (done),
        .pe_rst_n  (pe_rst_n),
        .pe_ctl    (pe_ctl),
        .feed_cnt  (feed_cnt),
        .row_en    (row_en),
        .col_en    (col_en),
        .out_valid (out_valid),
        .out_col   (out_col)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            passes++;
        end else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [KW-1:0] k);
        start = s;
        k_len = k;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_ctl"}, 32'(pe_ctl), 32'd0);
        checkOutput({tag, "_fcnt"}, 32'(feed_cnt), 32'd0);
        checkOutput({tag, "_row"}, 32'(row_en), 32'd0);
        checkOutput({tag, "_col"}, 32'(col_en), 32'd0);
        checkOutput({tag, "_ov"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_oc"}, 32'(out_col), 32'd0);
    endtask

    // Expected outputs in cycle c of a job whose start was sampled at the end of cycle b.
    task automatic checkCycle(input int c, input int b, input int k);
        int L, clr, f0, f1, cap, sh0, sh1, dn, t;
        logic [3:0] en;
        L   = k + 2 * N - 2;
        clr = b + 1;
        f0  = b + 2;
        f1  = b + 1 + L;
        cap = b + 2 + L;
        sh0 = cap + 1;
        sh1 = cap + N;
        dn  = cap + N + 1;
        t   = c - f0;
        en  = 4'b0000;
        if (c >= f0 && c <= f1) begin
            if (k == 4) en = tbl4[t];
            else if (k == 2) en = tbl2[t];
        end
        checkOutput($sformatf("busy@%0d", c), 32'(busy), 32'(c >= clr && c <= dn));
        checkOutput($sformatf("done@%0d", c), 32'(done), 32'(c == dn));
        checkOutput($sformatf("pe_rst_n@%0d", c), 32'(pe_rst_n), 32'(c != clr));
        checkOutput($sformatf("pe_ctl@%0d", c), 32'(pe_ctl), 32'(c == cap));
        checkOutput($sformatf("out_valid@%0d", c), 32'(out_valid), 32'(c >= sh0 && c <= sh1));
        checkOutput($sformatf("out_col@%0d", c), 32'(out_col),
                    (c >= sh0 && c <= sh1) ? 32'(sh1 - c) : 32'd0);
        checkOutput($sformatf("feed_cnt@%0d", c), 32'(feed_cnt),
                    (c >= f0 && c <= f1) ? 32'(t) : 32'd0);
        checkOutput($sformatf("row_en@%0d", c), 32'(row_en), 32'(en));
        checkOutput($sformatf("col_en@%0d", c), 32'(col_en), 32'(en));
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0);
`ifdef PE_ARRAY_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        #2;
        checkIdleOutputs("reset");
        checkOutput("reset_pe_rst_n", 32'(pe_rst_n), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("post_rst_pe_rst_n_low", 32'(pe_rst_n), 32'd0);
        stepCycle();
        checkOutput("post_rst_pe_rst_n_high", 32'(pe_rst_n), 32'd1);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);

        // Job 1 (k=4) with starts at cycles 5 and 12 ignored and k_len changing mid-job,
        // then job 2 (k=0) accepted from the IDLE cycle right after done.
        $display("[TB] job k=4, ignored starts, back-to-back k=0 job");
        cyc = 0;
        applyStimulus(1'b1, 8'd4);
        for (int c = 1; c <= 32; c++) begin
            stepCycle();
            if (c <= 18) checkCycle(c, 0, 4);
            else checkCycle(c, 18, 0);
            if (c == 18) applyStimulus(1'b1, 8'd0);
            else if (c == 5 || c == 12) applyStimulus(1'b1, 8'd1);
            else applyStimulus(1'b0, 8'd7);
        end

        // Reset asserted mid-FEED.
        $display("[TB] asynchronous reset mid-FEED");
        cyc = 0;
        applyStimulus(1'b1, 8'd4);
        for (int c = 1; c <= 7; c++) begin
            stepCycle();
            checkCycle(c, 0, 4);
            applyStimulus(1'b0, 8'd4);
        end
        #2;
        rst = 1'b1;
        #1;
        checkIdleOutputs("midrst");
        checkOutput("midrst_pe_rst_n", 32'(pe_rst_n), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midrst_release_pe_rst_n", 32'(pe_rst_n), 32'd0);
        for (int c = 0; c < 4; c++) begin
            stepCycle();
            checkOutput($sformatf("after_rst_busy%0d", c), 32'(busy), 32'd0);
            checkOutput($sformatf("after_rst_done%0d", c), 32'(done), 32'd0);
            checkOutput($sformatf("after_rst_pe_rst_n%0d", c), 32'(pe_rst_n), 32'd1);
        end
        cyc = 0;
        applyStimulus(1'b1, 8'd2);
        for (int c = 1; c <= 17; c++) begin
            stepCycle();
            checkCycle(c, 0, 2);
            applyStimulus(1'b0, 8'd2);
        end

`ifdef PE_ARRAY_CTRL_ABORT_EN
        $display("[TB] abort during SHIFT");
        cyc = 0;
        applyStimulus(1'b1, 8'd4);
        for (int c = 1; c <= 14; c++) begin
            stepCycle();
            checkCycle(c, 0, 4);
            checkOutput($sformatf("aborted@%0d", c), 32'(aborted), 32'd0);
            applyStimulus(1'b0, 8'd4);
            abort = (c == 14);
        end
        stepCycle();
        abort = 1'b0;
        checkOutput("abort_pulse", 32'(aborted), 32'd1);
        checkIdleOutputs("abort15");
        for (int c = 16; c <= 20; c++) begin
            stepCycle();
            checkOutput($sformatf("abort_done@%0d", c), 32'(done), 32'd0);
            checkOutput($sformatf("abort_aborted@%0d", c), 32'(aborted), 32'd0);
        end

        $display("[TB] abort in IDLE, then abort coinciding with start");
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        checkOutput("idle_abort_busy", 32'(busy), 32'd0);
        checkOutput("idle_abort_aborted", 32'(aborted), 32'd0);
        cyc = 0;
        applyStimulus(1'b1, 8'd4);
        abort = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            stepCycle();
            abort = 1'b0;
            checkCycle(c, 0, 4);
            applyStimulus(1'b0, 8'd4);
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
